// File: rtl/io_interface_if.sv
// ----------------------------------------------------------------------------
// io_interface_if
// Load/store bus between the RISC-V datapath and the memory-mapped UART port.
//   rd2       store data (byte rd2[7:0] is transmitted)
//   Addr      full 32-bit byte address
//   IO_trans  store byte-enable mask, any set bit marks a store
//   IO_recv   load strobe
//   Received  combinational read data for Addr
// Modports: master = datapath side, slave = UART port side.
// ----------------------------------------------------------------------------
interface io_interface_if;
    logic [31:0] rd2;
    logic [31:0] Addr;
    logic [3:0]  IO_trans;
    logic        IO_recv;
    logic [31:0] Received;

    modport master (output rd2, output Addr, output IO_trans, output IO_recv,
                    input Received);
    modport slave  (input rd2, input Addr, input IO_trans, input IO_recv,
                    output Received);
endinterface

// File: rtl/io_interface.sv
// ----------------------------------------------------------------------------
// io_interface
// Memory-mapped 8N1 UART port in the 0x8000_00xx I/O window.
//   0x8000_0000  status  {30'b0, rx_valid, tx_ready}   (read-only)
//   0x8000_0004  rx data {24'b0, rx_data}              (read-only)
//   0x8000_0008  tx data, store sends rd2[7:0]         (reads 0)
//   0x8000_0010  cycle counter                          (CYCLE_COUNTER_EN)
//   0x8000_0018  store clears the cycle counter         (CYCLE_COUNTER_EN)
// Optional feature macro: CYCLE_COUNTER_EN.
// Ports:
//   Clock, Reset  clock and asynchronous active-low reset
//   bus           io_interface_if.slave load/store bus
//   FPGA_Sin      serial input (idle high)
//   FPGA_Sout     serial output (idle high)
//   tx_state_dbg  TX FSM state, rx_state_dbg  RX FSM state
// Handshake: a store to the tx data address is the valid, tx_ready is the
// ready; a byte transfers on the rising edge where both are high. A store
// presented while tx_ready is low is dropped, never queued.
// ----------------------------------------------------------------------------
module io_interface #(
    parameter int ClockFreq = 100_000_000,
    parameter int BaudRate  = 115_200
) (
    input  logic          Clock,
    input  logic          Reset,
    io_interface_if.slave bus,
    input  logic          FPGA_Sin,
    output logic          FPGA_Sout,
    output logic [1:0]    tx_state_dbg,
    output logic [1:0]    rx_state_dbg
);
    localparam int SE   = ClockFreq / BaudRate;
    localparam int HALF = (SE / 2 > 0) ? SE / 2 : 1;
    localparam int CW   = (SE > 1) ? $clog2(SE) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(SE - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    localparam logic [31:0] ADDR_STATUS  = 32'h8000_0000;
    localparam logic [31:0] ADDR_RX_DATA = 32'h8000_0004;
    localparam logic [31:0] ADDR_TX_DATA = 32'h8000_0008;

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} uart_state_t;

    logic store;
    logic tx_ready, tx_accept, tx_bit_end;
    logic rx_consume;
    logic unused_rd2_bits;

    assign store      = |bus.IO_trans;
    assign rx_consume = bus.IO_recv && (bus.Addr == ADDR_RX_DATA);
    assign unused_rd2_bits = ^bus.rd2[31:8];

    // ---------------------------------------------------------------- TX
    uart_state_t   tx_state, tx_next;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    assign tx_ready   = (tx_state == IDLE);
    assign tx_accept  = store && (bus.Addr == ADDR_TX_DATA) && tx_ready;
    assign tx_bit_end = (tx_cnt == BIT_LAST);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= 8'h00;
        end else if (tx_accept) begin
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_shift <= bus.rd2[7:0];
        end else if (tx_state != IDLE) begin
            if (tx_bit_end) begin
                tx_cnt <= '0;
                if (tx_state == DATA) begin
                    tx_shift <= {1'b0, tx_shift[7:1]};
                    tx_bit   <= tx_bit + 3'd1;
                end
            end else begin
                tx_cnt <= tx_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            IDLE:  if (tx_accept) tx_next = START;
            START: if (tx_bit_end) tx_next = DATA;
            DATA:  if (tx_bit_end && tx_bit == 3'd7) tx_next = STOP;
            STOP:  if (tx_bit_end) tx_next = IDLE;
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        FPGA_Sout = 1'b1;
        case (tx_state)
            START:   FPGA_Sout = 1'b0;
            DATA:    FPGA_Sout = tx_shift[0];
            default: FPGA_Sout = 1'b1;
        endcase
    end

    // ---------------------------------------------------------------- RX
    uart_state_t   rx_state, rx_next;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift, rx_data;
    logic          rx_valid;
    logic          sin_s1, sin_s2, sin_prev;
    logic          rx_fall, rx_bit_end, rx_half_end;
    logic          rx_cnt_wrap, rx_sample_data, rx_done;

    assign rx_fall     = sin_prev && !sin_s2;
    assign rx_bit_end  = (rx_cnt == BIT_LAST);
    assign rx_half_end = (rx_cnt == HALF_LAST);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            sin_s1   <= 1'b1;
            sin_s2   <= 1'b1;
            sin_prev <= 1'b1;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            sin_s1   <= FPGA_Sin;
            sin_s2   <= sin_s1;
            sin_prev <= sin_s2;
            if (rx_state == IDLE || rx_cnt_wrap) rx_cnt <= '0;
            else                                 rx_cnt <= rx_cnt + 1'b1;
            if (rx_state == IDLE) begin
                rx_bit <= 3'd0;
            end else if (rx_sample_data) begin
                rx_shift <= {sin_s2, rx_shift[7:1]};
                rx_bit   <= rx_bit + 3'd1;
            end
            // A completing byte outranks a consume on the same edge.
            if (rx_done) begin
                rx_data  <= rx_shift;
                rx_valid <= 1'b1;
            end else if (rx_consume) begin
                rx_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:  if (rx_fall) rx_next = START;
            // Start bit re-checked half a bit in; a high line means a glitch.
            START: if (rx_half_end) rx_next = sin_s2 ? IDLE : DATA;
            DATA:  if (rx_bit_end && rx_bit == 3'd7) rx_next = STOP;
            STOP:  if (rx_bit_end) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    // After the half-bit start check the counter is mid-bit aligned, so every
    // full-period wrap lands in the middle of the next bit.
    always_comb begin
        rx_cnt_wrap    = (rx_state == START) ? rx_half_end : rx_bit_end;
        rx_sample_data = (rx_state == DATA) && rx_bit_end;
        rx_done        = (rx_state == STOP) && rx_bit_end && sin_s2;
    end

    // ------------------------------------------------------ cycle counter
`ifdef CYCLE_COUNTER_EN
    localparam logic [31:0] ADDR_CYCLES     = 32'h8000_0010;
    localparam logic [31:0] ADDR_CYCLES_CLR = 32'h8000_0018;
    logic [31:0] cyc_cnt;

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset)                                   cyc_cnt <= 32'd0;
        else if (store && bus.Addr == ADDR_CYCLES_CLR) cyc_cnt <= 32'd0;
        else                                          cyc_cnt <= cyc_cnt + 32'd1;
    end
`endif

    // ------------------------------------------------------ read mux
    always_comb begin
        bus.Received = 32'd0;
        case (bus.Addr)
            ADDR_STATUS:  bus.Received = {30'd0, rx_valid, tx_ready};
            ADDR_RX_DATA: bus.Received = {24'd0, rx_data};
`ifdef CYCLE_COUNTER_EN
            ADDR_CYCLES:  bus.Received = cyc_cnt;
`endif
            default:      bus.Received = 32'd0;
        endcase
    end

    assign tx_state_dbg = tx_state;
    assign rx_state_dbg = rx_state;
endmodule

// File: tb/tb_io_interface.sv
// ----------------------------------------------------------------------------
// tb_io_interface
// Directed bench for io_interface at 10 clock cycles per serial bit.
// A reference UART drives FPGA_Sin and decodes FPGA_Sout.
// ----------------------------------------------------------------------------
module tb_io_interface;
    localparam logic [31:0] A_STATUS = 32'h8000_0000;
    localparam logic [31:0] A_RXDATA = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam int BIT_CYC = 10;

    // ------------------------------------------------ clock / reset
    logic       Clock = 1'b0;
    logic       Reset;
    logic       FPGA_Sin;
    logic       FPGA_Sout;
    logic [1:0] tx_state_dbg, rx_state_dbg;

    always #5 Clock = ~Clock;

    io_interface_if bus ();

    io_interface #(.ClockFreq(1_000_000), .BaudRate(100_000)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .bus          (bus),
        .FPGA_Sin     (FPGA_Sin),
        .FPGA_Sout    (FPGA_Sout),
        .tx_state_dbg (tx_state_dbg),
        .rx_state_dbg (rx_state_dbg)
    );

    // ------------------------------------------------ scoreboard
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] mon_byte;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_tx_bytes(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, {24'd0, got_q.pop_front()}, {24'd0, exp_q.pop_front()});
        got_q.delete();
        exp_q.delete();
    endtask

    // ------------------------------------------------ driver tasks
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            FPGA_Sin = frame[i];
            repeat (BIT_CYC) @(negedge Clock);
        end
        FPGA_Sin = 1'b1;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.Addr = addr;
        #1;
        check(tag, bus.Received, exp);
    endtask

    // Reference receiver on FPGA_Sout, sampling mid-bit on negedges.
    initial begin
        forever begin
            @(negedge FPGA_Sout);
            repeat (BIT_CYC / 2) @(negedge Clock);
            if (FPGA_Sout === 1'b0) begin
                for (int i = 0; i < 8; i++) begin
                    repeat (BIT_CYC) @(negedge Clock);
                    mon_byte[i] = FPGA_Sout;
                end
                repeat (BIT_CYC) @(negedge Clock);
                if (FPGA_Sout === 1'b1) got_q.push_back(mon_byte);
                else                    got_q.push_back(8'hxx);
            end
        end
    end

    // ------------------------------------------------ directed sequence
    initial begin
        Reset        = 1'b0;
        FPGA_Sin     = 1'b1;
        bus.rd2      = 32'd0;
        bus.Addr     = A_STATUS;
        bus.IO_trans = 4'd0;
        bus.IO_recv  = 1'b0;
        repeat (2) @(negedge Clock);
        check("rst_sout", {31'd0, FPGA_Sout}, 32'd1);
        read_check("rst_status", A_STATUS, 32'h1);
        Reset = 1'b1;
        @(negedge Clock);
        read_check("rst_rxdata", A_RXDATA, 32'h0);
        read_check("txdata_reads0", A_TXDATA, 32'h0);
        read_check("unmapped_0x03", 32'h8000_0003, 32'h0);
        read_check("unmapped_0x0c", 32'h8000_000C, 32'h0);
`ifndef CYCLE_COUNTER_EN
        read_check("no_counter", 32'h8000_0010, 32'h0);
`endif

        // RX of 0xAA, then consume with a load held two cycles
        send_byte(8'hAA, 1'b1);
        read_check("rx_aa_status", A_STATUS, 32'h3);
        bus.Addr = A_RXDATA; bus.IO_recv = 1'b1;
        #1 check("rx_aa_load_c1", bus.Received, 32'hAA);
        @(negedge Clock);
        #1 check("rx_aa_load_c2", bus.Received, 32'hAA);
        @(negedge Clock);
        bus.IO_recv = 1'b0;
        read_check("rx_consumed_status", A_STATUS, 32'h1);

        // TX of 0xFF, store held two cycles -> exactly one byte
        @(negedge Clock);
        bus.Addr = A_TXDATA; bus.rd2 = 32'hFFFF_FFFF; bus.IO_trans = 4'b0001;
        exp_q.push_back(8'hFF);
        @(negedge Clock);
        check("tx_start_bit", {31'd0, FPGA_Sout}, 32'd0);
        @(negedge Clock);
        bus.IO_trans = 4'd0;
        read_check("tx_busy_early", A_STATUS, 32'h0);
        repeat (40) @(negedge Clock);
        read_check("tx_busy_mid", A_STATUS, 32'h0);
        repeat (58) @(negedge Clock);
        read_check("tx_busy_last", A_STATUS, 32'h0);
        @(negedge Clock);
        read_check("tx_ready_back", A_STATUS, 32'h1);
        repeat (20) @(negedge Clock);
        check_tx_bytes("tx_ff");

        // TX of 0x35, single-cycle store, checks bit order
        bus.Addr = A_TXDATA; bus.rd2 = 32'h0000_0035; bus.IO_trans = 4'b0100;
        exp_q.push_back(8'h35);
        @(negedge Clock);
        bus.IO_trans = 4'd0;
        repeat (110) @(negedge Clock);
        check_tx_bytes("tx_35");

        // Store to an unmapped address sends nothing
        bus.Addr = 32'h8000_000C; bus.rd2 = 32'h0000_0055; bus.IO_trans = 4'b1000;
        @(negedge Clock);
        bus.IO_trans = 4'd0;
        read_check("ignored_store_status", A_STATUS, 32'h1);
        repeat (110) @(negedge Clock);
        check_tx_bytes("ignored_store");

        // Back-to-back RX without a load: last byte wins, valid stays set
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        read_check("b2b_status", A_STATUS, 32'h3);
        read_check("b2b_data", A_RXDATA, 32'h34);
        bus.IO_recv = 1'b1;
        @(negedge Clock);
        bus.IO_recv = 1'b0;
        read_check("b2b_consumed", A_STATUS, 32'h1);

        // Framing error: stop bit 0 discards the byte
        send_byte(8'h5A, 1'b0);
        repeat (20) @(negedge Clock);
        read_check("frame_err_status", A_STATUS, 32'h1);
        read_check("frame_err_data", A_RXDATA, 32'h34);

        // Reset in the middle of a TX frame of 0x00
        bus.Addr = A_TXDATA; bus.rd2 = 32'h0; bus.IO_trans = 4'b0001;
        @(negedge Clock);
        bus.IO_trans = 4'd0;
        repeat (30) @(negedge Clock);
        check("midframe_sout_low", {31'd0, FPGA_Sout}, 32'd0);
        Reset = 1'b0;
        #1 check("midreset_sout", {31'd0, FPGA_Sout}, 32'd1);
        read_check("midreset_status", A_STATUS, 32'h1);
        read_check("midreset_rxdata", A_RXDATA, 32'h0);
        @(negedge Clock);
        Reset = 1'b1;
        repeat (120) @(negedge Clock);
        got_q.delete();

`ifdef CYCLE_COUNTER_EN
        bus.Addr = 32'h8000_0018; bus.IO_trans = 4'b0001;
        @(negedge Clock);
        bus.IO_trans = 4'd0;
        bus.Addr = 32'h8000_0010;
        repeat (5) @(negedge Clock);
        read_check("cycle_counter", 32'h8000_0010, 32'd5);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
